// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit.
//   pred_entry_t : one in-flight prediction {taken, pc, target}
//   bru_state_t  : resolve FSM states
//   INSTR_BYTES  : fall-through step used for not-taken redirects
package bru_pkg;
  localparam int INSTR_BYTES = 4;
  // Entry field width. The top's XLEN must match it.
  localparam int PC_W = 32;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bru_state_t;

  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] target;
  } pred_entry_t;
endpackage

// File: rtl/bru_pred_fifo.sv
// In-order FIFO of in-flight predictions.
//   push/wdata : enqueue when not full
//   pop/rdata  : rdata shows the head, and the head is dequeued when not empty
//   clear      : empties the queue; it takes priority over push and pop
//   count/full/empty : occupancy. The explicit counter removes any full/empty ambiguity.
module bru_pred_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 65,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of 2, so the pointers wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage has no reset. The entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves fetch-time branch predictions against EX outcomes.
//   pred_*      : prediction push from fetch, and pred_ready back-pressure
//   ex_*        : resolution of the oldest in-flight branch
//   upd_*       : predictor update strobe and outcome (registered)
//   flush/redirect_pc : one-cycle squash and restart PC on a mispredict
//   inflight, br_count, mp_count, underflow_err : status and saturating counters
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pred_valid,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_pc,
  input  logic [XLEN-1:0] pred_target,
  output logic            pred_ready,
  input  logic            ex_valid,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic            upd_valid,
  output logic            upd_outcome,
  output logic            flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic [CW-1:0]   inflight,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count,
  output logic            underflow_err
);
  bru_state_t  state, state_nxt;
  pred_entry_t wentry, head;
  logic        full, empty, push, pop, mispredict;

  // Ready depends only on registered state. A pop in this same cycle does not free a slot early.
  assign pred_ready = (state == RUN) && !full;
  assign push       = pred_valid && pred_ready;
  assign pop        = ex_valid && (state == RUN) && !empty;
  assign mispredict = pop && ((head.taken != ex_taken) ||
                              (ex_taken && (head.target != ex_target)));

  assign wentry = '{taken: pred_taken, pc: pred_pc, target: pred_target};

  bru_pred_fifo #(.DEPTH(DEPTH), .W($bits(pred_entry_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (mispredict),   // same-cycle push is dropped with the wrong path
    .wdata (wentry),
    .rdata (head),
    .count (inflight),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (mispredict) state_nxt = RECOVER;
      RECOVER: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RUN;
      upd_valid     <= 1'b0;
      upd_outcome   <= 1'b0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      br_count      <= '0;
      mp_count      <= '0;
      underflow_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      upd_valid   <= pop;
      upd_outcome <= pop && ex_taken;
      flush       <= mispredict;
      if (mispredict)
        redirect_pc <= ex_taken ? ex_target : head.pc + XLEN'(INSTR_BYTES);
      if (pop && (br_count != '1))
        br_count <= br_count + 1'b1;
      if (mispredict && (mp_count != '1))
        mp_count <= mp_count + 1'b1;
      if (ex_valid && (state == RUN) && empty)
        underflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  localparam int XLEN = 32, DEPTH = 4, CNT_W = 16, CW = 3;

  logic clk = 1'b0;
  logic rst_n, pred_valid, pred_taken, ex_valid, ex_taken;
  logic [XLEN-1:0] pred_pc, pred_target, ex_target, redirect_pc;
  logic pred_ready, upd_valid, upd_outcome, flush, underflow_err;
  logic [CW-1:0] inflight;
  logic [CNT_W-1:0] br_count, mp_count;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
    .pred_target(pred_target), .pred_ready(pred_ready),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_target(ex_target),
    .upd_valid(upd_valid), .upd_outcome(upd_outcome), .flush(flush),
    .redirect_pc(redirect_pc), .inflight(inflight), .br_count(br_count),
    .mp_count(mp_count), .underflow_err(underflow_err)
  );

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: a queue of predictions plus plain counters
  typedef struct { bit taken; bit [31:0] pc; bit [31:0] target; } ent_t;
  ent_t q[$];
  bit   m_rec, m_uf, e_upd, e_out, e_fl;
  bit [31:0] e_redir;
  int   m_br, m_mp;

  function automatic void model_reset();
    q.delete(); m_rec = 0; m_uf = 0; e_upd = 0; e_out = 0; e_fl = 0;
    e_redir = 0; m_br = 0; m_mp = 0;
  endfunction

  function automatic void model_step(bit pv, bit pt, bit [31:0] ppc, bit [31:0] ptg,
                                     bit ev, bit et, bit [31:0] etg);
    bit rdy = !m_rec && q.size() < DEPTH;
    bit popq = ev && !m_rec && q.size() > 0;
    bit mp = 0;
    ent_t h;
    if (popq) begin
      h = q[0];
      mp = (h.taken != et) || (et && h.target != etg);
    end
    if (ev && !m_rec && q.size() == 0) m_uf = 1;
    e_upd = popq; e_out = popq && et; e_fl = mp;
    if (mp) e_redir = et ? etg : h.pc + 32'd4;
    if (popq && m_br < 65535) m_br++;
    if (mp && m_mp < 65535) m_mp++;
    if (popq) void'(q.pop_front());
    if (rdy && pv) q.push_back('{pt, ppc, ptg});
    if (mp) q.delete();
    m_rec = mp;
  endfunction

  // Drive one cycle of inputs, clock the DUT, and leave time 1 after the edge
  task automatic apply(input bit rst, input bit pv, input bit pt, input bit [31:0] ppc,
                       input bit [31:0] ptg, input bit ev, input bit et, input bit [31:0] etg);
    rst_n = !rst; pred_valid = pv; pred_taken = pt; pred_pc = ppc; pred_target = ptg;
    ex_valid = ev; ex_taken = et; ex_target = etg;
    if (rst) model_reset();
    else model_step(pv, pt, ppc, ptg, ev, et, etg);
    @(posedge clk); #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".upd_valid"},   64'(upd_valid),     64'(e_upd));
    check({tag, ".upd_outcome"}, 64'(upd_outcome),   64'(e_out));
    check({tag, ".flush"},       64'(flush),         64'(e_fl));
    check({tag, ".redirect_pc"}, 64'(redirect_pc),   64'(e_redir));
    check({tag, ".inflight"},    64'(inflight),      64'(q.size()));
    check({tag, ".br_count"},    64'(br_count),      64'(m_br));
    check({tag, ".mp_count"},    64'(mp_count),      64'(m_mp));
    check({tag, ".pred_ready"},  64'(pred_ready),    64'(!m_rec && q.size() < DEPTH));
    check({tag, ".underflow"},   64'(underflow_err), 64'(m_uf));
  endtask

  typedef struct {
    bit pv, pt; bit [31:0] ppc, ptg; bit ev, et; bit [31:0] etg;
    bit upd, out, fl; bit [31:0] redir; int inf, br, mp; bit rdy, uf;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(bit pv, bit pt, bit [31:0] ppc, bit [31:0] ptg,
                              bit ev, bit et, bit [31:0] etg,
                              bit upd, bit out, bit fl, bit [31:0] redir,
                              int inf, int br, int mp, bit rdy, bit uf);
    tbl.push_back('{pv, pt, ppc, ptg, ev, et, etg, upd, out, fl, redir, inf, br, mp, rdy, uf});
  endfunction

  initial begin
    rst_n = 0; pred_valid = 0; pred_taken = 0; pred_pc = 0; pred_target = 0;
    ex_valid = 0; ex_taken = 0; ex_target = 0;
    @(posedge clk); #1;
    apply(1, 1, 1, 32'h10, 32'h20, 1, 1, 0);
    check("reset.upd_valid", 64'(upd_valid), 0);
    check("reset.flush", 64'(flush), 0);
    check("reset.inflight", 64'(inflight), 0);
    check("reset.pred_ready", 64'(pred_ready), 1);
    check("reset.br_count", 64'(br_count), 0);

    //   pv pt ppc      ptg      ev et etg     | upd out fl redir   inf br mp rdy uf
    add(1, 1, 'h100,  'h200,   0, 0, 0,        0, 0, 0, 0,      1, 0, 0, 1, 0);
    add(0, 0, 0,      0,       1, 1, 'h200,    1, 1, 0, 0,      0, 1, 0, 1, 0);
    add(1, 0, 'h140,  0,       0, 0, 0,        0, 0, 0, 0,      1, 1, 0, 1, 0);
    add(0, 0, 0,      0,       1, 1, 'h180,    1, 1, 1, 'h180,  0, 2, 1, 0, 0);
    add(0, 0, 0,      0,       1, 1, 'h180,    0, 0, 0, 'h180,  0, 2, 1, 1, 0); // RECOVER: ev ignored
    add(1, 1, 'h40,   'h80,    0, 0, 0,        0, 0, 0, 'h180,  1, 2, 1, 1, 0);
    add(0, 0, 0,      0,       1, 0, 0,        1, 0, 1, 'h44,   0, 3, 2, 0, 0);
    add(0, 0, 0,      0,       0, 0, 0,        0, 0, 0, 'h44,   0, 3, 2, 1, 0);
    add(1, 1, 'h40,   'h80,    0, 0, 0,        0, 0, 0, 'h44,   1, 3, 2, 1, 0);
    add(0, 0, 0,      0,       1, 1, 'h90,     1, 1, 1, 'h90,   0, 4, 3, 0, 0);
    add(0, 0, 0,      0,       0, 0, 0,        0, 0, 0, 'h90,   0, 4, 3, 1, 0);
    add(1, 0, 'h1000, 0,       0, 0, 0,        0, 0, 0, 'h90,   1, 4, 3, 1, 0);
    add(1, 0, 'h1010, 0,       0, 0, 0,        0, 0, 0, 'h90,   2, 4, 3, 1, 0);
    add(1, 0, 'h1020, 0,       0, 0, 0,        0, 0, 0, 'h90,   3, 4, 3, 1, 0);
    add(1, 0, 'h1030, 0,       0, 0, 0,        0, 0, 0, 'h90,   4, 4, 3, 0, 0);
    add(1, 1, 'h999,  'h999,   0, 0, 0,        0, 0, 0, 'h90,   4, 4, 3, 0, 0); // full: push ignored
    add(1, 1, 'h999,  'h999,   1, 0, 0,        1, 0, 0, 'h90,   3, 5, 3, 1, 0); // pop while full: no push
    add(1, 1, 'h3000, 'h3100,  1, 1, 'h2000,   1, 1, 1, 'h2000, 0, 6, 4, 0, 0); // push discarded
    add(0, 0, 0,      0,       0, 0, 0,        0, 0, 0, 'h2000, 0, 6, 4, 1, 0);
    add(0, 0, 0,      0,       1, 1, 'h5,      0, 0, 0, 'h2000, 0, 6, 4, 1, 1); // underflow
    add(0, 0, 0,      0,       0, 0, 0,        0, 0, 0, 'h2000, 0, 6, 4, 1, 1);

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      apply(0, tbl[i].pv, tbl[i].pt, tbl[i].ppc, tbl[i].ptg, tbl[i].ev, tbl[i].et, tbl[i].etg);
      check({t, ".upd_valid"},   64'(upd_valid),     64'(tbl[i].upd));
      check({t, ".upd_outcome"}, 64'(upd_outcome),   64'(tbl[i].out));
      check({t, ".flush"},       64'(flush),         64'(tbl[i].fl));
      check({t, ".redirect_pc"}, 64'(redirect_pc),   64'(tbl[i].redir));
      check({t, ".inflight"},    64'(inflight),      64'(tbl[i].inf));
      check({t, ".br_count"},    64'(br_count),      64'(tbl[i].br));
      check({t, ".mp_count"},    64'(mp_count),      64'(tbl[i].mp));
      check({t, ".pred_ready"},  64'(pred_ready),    64'(tbl[i].rdy));
      check({t, ".underflow"},   64'(underflow_err), 64'(tbl[i].uf));
    end

    // Randomized traffic against the queue model
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      bit pv, pt, ev, et;
      bit [31:0] ppc, ptg, etg;
      pv = ($urandom_range(9, 0) < 6);
      pt = $urandom_range(1, 0);
      ppc = 32'($urandom_range(255, 0)) << 2;
      ptg = 32'($urandom_range(3, 0)) << 8;
      ev = $urandom_range(1, 0);
      et = $urandom_range(1, 0);
      etg = 32'($urandom_range(3, 0)) << 8;
      if (q.size() > 0 && $urandom_range(3, 0) != 0) begin
        et = q[0].taken;
        if (q[0].taken) etg = q[0].target;
      end
      apply(0, pv, pt, ppc, ptg, ev, et, etg);
      check_model($sformatf("rnd%0d", i));
    end

    // Reset asserted while flush is high
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 'h500, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 1, 1, 'h600);
    check("midflush.flush_before", 64'(flush), 1);
    apply(1, 1, 1, 'h700, 'h800, 1, 1, 0);
    check("midflush.flush", 64'(flush), 0);
    check("midflush.redirect_pc", 64'(redirect_pc), 0);
    check("midflush.mp_count", 64'(mp_count), 0);
    check("midflush.inflight", 64'(inflight), 0);
    check("midflush.pred_ready", 64'(pred_ready), 1);

    // Saturation: a push and a correct pop every cycle keeps one entry in flight
    apply(0, 1, 1, 'h0, 'h0, 0, 0, 0);
    for (int i = 0; i < 65535; i++) apply(0, 1, 1, 'h0, 'h0, 1, 1, 'h0);
    check("sat.br_at_max", 64'(br_count), 64'hFFFF);
    apply(0, 1, 1, 'h0, 'h0, 1, 1, 'h0);
    check("sat.br_held", 64'(br_count), 64'hFFFF);
    check("sat.upd_valid", 64'(upd_valid), 1);
    check_model("sat");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
